// File: rtl/rd_cap_pkg.sv
// ----------------------------------------------------------------------------
// rd_cap_pkg
// Shared definitions for the read-data capture block: the burst FSM state
// encoding and the default sizing constants used by rd_capture and sync_fifo.
// ----------------------------------------------------------------------------
package rd_cap_pkg;

    localparam int DEF_DW       = 8;  // data word width
    localparam int DEF_DEPTH    = 8;  // FIFO depth in words (power of two)
    localparam int DEF_AW       = 3;  // pointer width, log2(DEF_DEPTH)
    localparam int DEF_MIN_ROOM = 4;  // free entries needed to raise room
    localparam int DEF_LENW     = 8;  // burst-length counter width

    // Burst tracking FSM.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        DONE    = 2'b10
    } state_t;

endpackage : rd_cap_pkg

// File: rtl/rd_capture_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with an extra occupancy bit so that full (DEPTH) and
// empty (0) are distinct. The head word is read straight from the storage
// array, so it changes only when the read pointer moves.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (pointers/occupancy only)
//   i_push   in   write request; accepted unless full without a same-cycle pop
//   i_pop    in   read request; accepted only when non-empty
//   i_wdata  in   DW  write data
//   o_rdata  out  DW  head word (don't-care while empty)
//   o_full   out  occupancy == DEPTH
//   o_empty  out  occupancy == 0
//   o_count  out  AW+1  occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo
    import rd_cap_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_wr_en;
    logic w_rd_en;

    // A pop frees the slot the push would need, so a full FIFO still takes
    // a push when it is popped in the same cycle.
    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (!w_wr_en && w_rd_en) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy alone
    // defines which entries are meaningful, and an unreset array maps to RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == C_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule : sync_fifo

// File: rtl/rd_capture.sv
// ----------------------------------------------------------------------------
// rd_capture
// Captures strobed memory read data from the cliff read-control FSM into a
// FIFO, presents it on a valid/ready stream, and reports the length of each
// read burst (rd high period) with a one-cycle burst_done pulse.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   rd          in   read cycle active
//   rs          in   read strobe; mem_data valid when rd&rs
//   mem_data    in   DW    memory read data
//   out_data    out  DW    FIFO head word
//   out_valid   out  FIFO non-empty
//   out_ready   in   consumer accepts head word
//   room        out  free entries >= MIN_ROOM (gates upstream go)
//   burst_done  out  one-cycle pulse after a burst ends
//   burst_len   out  LENW  strobes counted in the last completed burst
//   overflow    out  sticky: a strobed word was dropped on a full FIFO
//   ovf_clr     in   clears overflow (a same-cycle drop wins)
// ----------------------------------------------------------------------------
module rd_capture
    import rd_cap_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = DEF_AW,
    parameter int MIN_ROOM = DEF_MIN_ROOM,
    parameter int LENW     = DEF_LENW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd,
    input  logic            rs,
    input  logic [DW-1:0]   mem_data,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            room,
    output logic            burst_done,
    output logic [LENW-1:0] burst_len,
    output logic            overflow,
    input  logic            ovf_clr
);

    localparam logic [AW:0]     C_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0]     C_MIN_ROOM = (AW+1)'(MIN_ROOM);
    localparam logic [LENW-1:0] C_CNT_MAX  = '1;
    localparam logic [LENW-1:0] C_CNT_ONE  = LENW'(1);

    state_t          r_state;
    state_t          w_state_next;
    logic [LENW-1:0] r_count;
    logic [LENW-1:0] w_count_next;
    logic [LENW-1:0] r_burst_len;
    logic [LENW-1:0] w_len_next;
    logic            w_burst_done;
    logic            r_overflow;

    logic            w_strobe;
    logic            w_drop;
    logic            w_full;
    logic            w_empty;
    logic [AW:0]     w_occ;
    logic [DW-1:0]   w_rdata;

    // rs outside a read cycle is noise from the FSM and is ignored entirely.
    assign w_strobe = rd & rs;

    // A full FIFO always has valid head, so a pop is exactly out_ready.
    assign w_drop = w_strobe & w_full & ~out_ready;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_strobe),
        .i_pop   (out_ready),
        .i_wdata (mem_data),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_len_next   = r_burst_len;
        w_burst_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd) begin
                    w_state_next = CAPTURE;
                    w_count_next = LENW'(rs);
                end
            end
            CAPTURE: begin
                if (rd) begin
                    // Saturate rather than wrap so a long burst never
                    // reports a misleadingly small length.
                    if (rs && (r_count != C_CNT_MAX)) begin
                        w_count_next = r_count + C_CNT_ONE;
                    end
                end else begin
                    w_state_next = DONE;
                    w_len_next   = r_count;
                end
            end
            DONE: begin
                w_burst_done = 1'b1;
                if (rd) begin
                    // Back-to-back burst: the rd edge here is the first
                    // cycle of the new burst, so load exactly as from IDLE.
                    w_state_next = CAPTURE;
                    w_count_next = LENW'(rs);
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_burst_len <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_burst_len <= w_len_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_data   = w_rdata;
    assign out_valid  = ~w_empty;
    assign room       = (C_DEPTH - w_occ) >= C_MIN_ROOM;
    assign burst_done = w_burst_done;
    assign burst_len  = r_burst_len;
    assign overflow   = r_overflow;

endmodule : rd_capture

// File: tb/tb_rd_capture.sv
// ----------------------------------------------------------------------------
// tb_rd_capture
// Directed stimulus for rd_capture with a decoupled scoreboard: expected data
// words and burst lengths are queued as stimulus is issued; a monitor pops
// and compares whenever the DUT hands over a word or pulses burst_done.
// ----------------------------------------------------------------------------
module tb_rd_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd;
    logic       rs;
    logic [7:0] mem_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       room;
    logic       burst_done;
    logic [7:0] burst_len;
    logic       overflow;
    logic       ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_data_q[$];
    logic [7:0] exp_len_q[$];

    rd_capture dut (
        .clk        (clk),
        .rst        (rst),
        .rd         (rd),
        .rs         (rs),
        .mem_data   (mem_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .room       (room),
        .burst_done (burst_done),
        .burst_len  (burst_len),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of upstream inputs, then settle just past the edge.
    task automatic step(input logic i_rd, input logic i_rs,
                        input logic [7:0] d);
        rd       = i_rd;
        rs       = i_rs;
        mem_data = d;
        @(posedge clk);
        #1;
    endtask

    // Strobed word that the FIFO is expected to keep.
    task automatic strobe(input logic [7:0] d);
        exp_data_q.push_back(d);
        step(1'b1, 1'b1, d);
    endtask

    // Monitor: sampled on the falling edge, i.e. just before the edge that
    // will complete any handshake seen here.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (out_valid && out_ready) begin
                    if (exp_data_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL data_unexpected: got 0x%0h, expected none",
                                 out_data);
                    end else begin
                        check("data_order", out_data, exp_data_q.pop_front());
                    end
                end
                if (burst_done) begin
                    if (exp_len_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL burst_done_unexpected: got len 0x%0h, expected no pulse",
                                 burst_len);
                    end else begin
                        check("burst_len", burst_len, exp_len_q.pop_front());
                    end
                end
            end
        end
    end

    // Watchdog: every wait below is a fixed cycle count, this only guards
    // against a simulator-level stall.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        rd        = 1'b0;
        rs        = 1'b0;
        mem_data  = 8'h00;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;

        // ---- reset and idle ------------------------------------------------
        repeat (5) step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        check("rst_out_valid",  out_valid,  0);
        check("rst_room",       room,       1);
        check("rst_burst_done", burst_done, 0);
        check("rst_burst_len",  burst_len,  0);
        check("rst_overflow",   overflow,   0);
        out_ready = 1'b1;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        // rs without rd must not capture anything.
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 8'h00);
        check("idle_rs_no_push", out_valid, 0);
        check("idle_burst_done", burst_done, 0);

        // ---- simple burst, 5 strobes, consumer always ready ----------------
        exp_len_q.push_back(8'd5);
        step(1'b1, 1'b0, 8'h00);
        strobe(8'h11);
        check("latency_valid", out_valid, 1);
        check("latency_data",  out_data,  8'h11);
        strobe(8'h12);
        strobe(8'h13);
        strobe(8'h14);
        strobe(8'h15);
        step(1'b1, 1'b0, 8'h00);
        check("b1_no_done_yet", burst_done, 0);
        step(1'b0, 1'b0, 8'h00);
        check("b1_done_pulse", burst_done, 1);
        check("b1_len",        burst_len,  5);
        step(1'b0, 1'b0, 8'h00);
        check("b1_done_single", burst_done, 0);
        check("b1_drained",     out_valid,  0);

        // ---- overflow: 10 strobes into 8 entries, consumer stalled --------
        out_ready = 1'b0;
        exp_len_q.push_back(8'd10);
        for (int i = 0; i < 8; i++) strobe(8'(i));
        check("full_room",     room,      0);
        check("full_valid",    out_valid, 1);
        check("full_no_ovf",   overflow,  0);
        step(1'b1, 1'b1, 8'h08);
        check("drop_ovf_set",  overflow,  1);
        step(1'b1, 1'b1, 8'h09);
        check("head_stable",   out_data,  8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("ovf_done_pulse", burst_done, 1);
        check("ovf_len",        burst_len,  10);
        out_ready = 1'b1;
        repeat (8) step(1'b0, 1'b0, 8'h00);
        check("ovf_drained",   out_valid, 0);
        check("ovf_room",      room,      1);
        check("ovf_sticky",    overflow,  1);
        ovf_clr = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        ovf_clr = 1'b0;
        check("ovf_cleared",   overflow,  0);

        // ---- full FIFO: push and pop in the same cycle ---------------------
        out_ready = 1'b0;
        exp_len_q.push_back(8'd9);
        for (int i = 0; i < 8; i++) strobe(8'hA0 + 8'(i));
        out_ready = 1'b1;
        strobe(8'hA8);
        check("pp_no_ovf",    overflow, 0);
        check("pp_head_adv",  out_data, 8'hA1);
        check("pp_room",      room,     0);
        // Exactly eight words must remain: A1..A8.
        repeat (8) step(1'b0, 1'b0, 8'h00);
        check("pp_occ_8",     out_valid, 0);
        check("pp_q_empty",   exp_data_q.size(), 0);

        // ---- back-to-back bursts via DONE -> CAPTURE -----------------------
        exp_len_q.push_back(8'd3);
        exp_len_q.push_back(8'd2);
        strobe(8'hB1);
        strobe(8'hB2);
        strobe(8'hB3);
        step(1'b0, 1'b0, 8'h00);
        check("bb1_done",     burst_done, 1);
        check("bb1_len",      burst_len,  3);
        strobe(8'hB4);
        check("bb_gap_done",  burst_done, 0);
        strobe(8'hB5);
        step(1'b0, 1'b0, 8'h00);
        check("bb2_done",     burst_done, 1);
        check("bb2_len",      burst_len,  2);
        repeat (2) step(1'b0, 1'b0, 8'h00);

        // ---- reset mid-burst -----------------------------------------------
        out_ready = 1'b0;
        strobe(8'hC1);
        strobe(8'hC2);
        strobe(8'hC3);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        exp_data_q.delete();
        check("mid_rst_valid", out_valid,  0);
        check("mid_rst_room",  room,       1);
        check("mid_rst_done",  burst_done, 0);
        check("mid_rst_len",   burst_len,  0);
        rst = 1'b0;
        out_ready = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        check("post_rst_no_done", burst_done, 0);
        exp_len_q.push_back(8'd2);
        strobe(8'hD1);
        strobe(8'hD2);
        step(1'b0, 1'b0, 8'h00);
        check("post_rst_done", burst_done, 1);
        check("post_rst_len",  burst_len,  2);
        repeat (3) step(1'b0, 1'b0, 8'h00);

        check("end_data_q_empty", exp_data_q.size(), 0);
        check("end_len_q_empty",  exp_len_q.size(),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rd_capture

// File: doc/rd_capture.md
Name: rd_capture

Overview:
- Sits directly downstream of the cliff read-control FSM. Consumes its rd (read cycle active) and rs (read strobe) outputs, together with the memory data bus.
- Captures each strobed data word into a small synchronous FIFO.
- Presents captured words on a valid/ready stream and reports burst boundaries and length.
- Drives a space-available flag that upstream logic uses to gate the FSM's go input.

Parameters:
- DW, 8, data word width in bits.
- DEPTH, 8, FIFO depth in words; power of two, minimum 2.
- AW, 3, pointer width; must equal log2(DEPTH).
- MIN_ROOM, 4, free entries required for room=1; range 1..DEPTH.
- LENW, 8, burst-length counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- rd  in  1  read cycle active, from cliff FSM.
- rs  in  1  read strobe, from cliff FSM; data valid this cycle.
- mem_data  in  DW  memory read data, sampled when rd&rs.
- out_data  out  DW  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head word.
- room  out  1  free entries >= MIN_ROOM.
- burst_done  out  1  one-cycle pulse at end of burst.
- burst_len  out  LENW  words captured in last completed burst; held until the next burst_done.
- overflow  out  1  sticky: a strobed word was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (rst=1 at a clock edge) forces: FIFO empty, pointers 0, state IDLE, out_valid=0, room=1, burst_done=0, burst_len=0, overflow=0, internal count=0. out_data is don't-care while out_valid=0.
- Reset mid-burst discards all stored words and the partial count. No burst_done is emitted for the aborted burst.
- Push: rd&rs at an edge writes mem_data, unless the FIFO is full and no pop occurs that cycle.
- Word captured at edge N is visible on out_data/out_valid after edge N, i.e. one-cycle latency.
- Pop: out_valid&out_ready at an edge advances the read pointer.
- out_data is a registered/RAM read of the head. It must be stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - Both are accepted in every occupancy, including full; occupancy is unchanged.
  - When empty, only the push occurs.
- Full with push and no pop: the word is dropped, overflow is set, and the burst count still increments.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra occupancy bit (0..DEPTH).
- room is combinational from occupancy: (DEPTH - occupancy) >= MIN_ROOM.
- ovf_clr has priority over a same-cycle set only if no drop occurs that cycle; drop wins.
- rs while rd=0 is ignored: no push, no count.
- FSM states:
  - IDLE -> CAPTURE when rd=1. The count loads 1 if rs=1 that cycle, else 0.
  - CAPTURE: increments count on each rs; stays while rd=1.
  - CAPTURE -> DONE when rd=0. The final count is latched into burst_len.
  - DONE: burst_done=1 for exactly this cycle.
  - DONE -> CAPTURE if rd=1 again (back-to-back burst, count reloads as in IDLE); else -> IDLE.
- Count saturates at 2^LENW-1; no wrap.
- A burst with zero strobes still produces burst_done, with burst_len=0.

Decomposition:
- Shared package rd_cap_pkg holds:
  - state enum {IDLE, CAPTURE, DONE}, encoded 2'b00/01/10;
  - default constants for DW, DEPTH, MIN_ROOM.
- One natural sub-module: sync_fifo (parameterised DW/DEPTH; push/pop/full/empty/count). It is instantiated once.
- The burst FSM, counter and overflow flag live in the top level.

Test Plan:
- Reset for 5 cycles, then idle with rd=rs=0 -> out_valid=0, room=1, burst_done=0, burst_len=0, overflow=0 throughout.
- rd=1 for 7 cycles, rs=1 on cycles 2-6 with mem_data 0x11..0x15, out_ready=1 -> words 0x11..0x15 emerge in order, each one cycle after capture; burst_done pulses one cycle after rd falls; burst_len=5.
- out_ready=0, one burst of 10 strobes with DEPTH=8, data 0x00..0x09 -> after the 8th word room=0 and out_valid=1; words 0x08 and 0x09 are dropped; overflow=1; burst_len=10. Then out_ready=1 drains exactly 0x00..0x07. ovf_clr -> overflow=0.
- Full FIFO with a push and a pop in the same cycle -> occupancy stays 8, overflow stays 0, the head advances, and the pushed word appears last.
- Back-to-back bursts (rd drops 1 cycle, rises with rs): burst 1 = 3 strobes, burst 2 = 2 strobes -> burst_done pulses twice, burst_len 3 then 2; the DONE->CAPTURE path is taken.
- rst asserted mid-burst after 3 captured words -> next edge: out_valid=0, room=1, no burst_done. A new 2-strobe burst after reset reports burst_len=2.
